axil_apb_bridge_multi: RTL

Parametrised AXI4-Lite slave to APB master bridge. It fans out to N_SLAVES APB peripherals that sit behind the processing-system interconnect.
- Address decode selects one slave per transaction.
- Read and write requests are arbitrated round-robin.
- An APB timeout watchdog bounds every access.
- Unmapped addresses return DECERR without any APB activity.

---
 rtl/axil_apb_bridge_pkg.sv | 30 +++
 rtl/apb_slave_decoder.sv | 24 ++
 rtl/axil_apb_bridge_multi.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axil_apb_bridge_pkg.sv
// Shared types for the AXI4-Lite to multi-slave APB bridge family.
// The transaction record is sized for the widest supported bus; users take the low bits they need.
package axil_apb_bridge_pkg;

  localparam int MAX_AW = 64;
  localparam int MAX_DW = 64;
  localparam int MAX_SW = MAX_DW / 8;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] data;
    logic [MAX_SW-1:0] strb;
    logic              write;
    logic [IDX_W-1:0]  index;
    logic              valid_decode;
  } txn_t;

endpackage

// File: rtl/apb_slave_decoder.sv
// Maps a byte address onto one of N_SLAVES equally sized windows starting at BASE_ADDRESS.
module apb_slave_decoder
  import axil_apb_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    SLAVE_SPAN_BITS = 12,
  parameter int                    N_SLAVES        = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS    = 'h43C00000
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  hit
);

  logic [ADDR_WIDTH-1:0] offs;
  logic [ADDR_WIDTH-1:0] slot;

  assign offs  = addr - BASE_ADDRESS;
  assign slot  = offs >> SLAVE_SPAN_BITS;
  // addresses below the base wrap to a huge slot, but the explicit compare keeps intent clear
  assign hit   = (addr >= BASE_ADDRESS) && (slot < ADDR_WIDTH'(N_SLAVES));
  assign index = slot[IDX_W-1:0];

endmodule

// File: rtl/axil_apb_bridge_multi.sv
// AXI4-Lite slave to N-port APB master: one transaction in flight, read/write round-robin,
// ACCESS-phase watchdog, DECERR for unmapped addresses without touching APB.
module axil_apb_bridge_multi
  import axil_apb_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    N_SLAVES        = 4,
  parameter int                    SLAVE_SPAN_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS    = 'h43C00000,
  parameter int                    TIMEOUT_CYCLES  = 256
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [DATA_WIDTH-1:0]        s_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [ADDR_WIDTH-1:0]        s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_WIDTH-1:0]        s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [ADDR_WIDTH-1:0]        m_paddr,
  output logic [DATA_WIDTH-1:0]        m_pwdata,
  output logic [DATA_WIDTH/8-1:0]      m_pstrb,
  output logic                         m_pwrite,
  output logic                         m_penable,
  output logic [2:0]                   m_pprot,
  output logic [N_SLAVES-1:0]          m_psel,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] m_prdata,
  input  logic [N_SLAVES-1:0]          m_pready,
  input  logic [N_SLAVES-1:0]          m_pslverr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = (ADDR_WIDTH'(1) << SLAVE_SPAN_BITS) - ADDR_WIDTH'(1);

  bridge_state_t         state_q, state_d;
  txn_t                  txn_q, txn_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pref_wr_q, pref_wr_d;

  logic                  idle, wr_elig, grant_wr, grant_rd, timeout;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [N_SLAVES-1:0]   sel_onehot;
  logic                  unused_txn;

  // reset gates the grant so no ready escapes while the bridge is held in reset
  assign idle     = (state_q == IDLE) && reset;
  assign wr_elig  = s_awvalid && s_wvalid;
  assign grant_wr = idle && wr_elig && (pref_wr_q || !s_arvalid);
  assign grant_rd = idle && s_arvalid && (!pref_wr_q || !wr_elig);
  assign req_addr = grant_wr ? s_awaddr : s_araddr;

  apb_slave_decoder #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SLAVE_SPAN_BITS(SLAVE_SPAN_BITS),
    .N_SLAVES       (N_SLAVES),
    .BASE_ADDRESS   (BASE_ADDRESS)
  ) u_dec (
    .addr (req_addr),
    .index(dec_idx),
    .hit  (dec_hit)
  );

  always_comb begin
    sel_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (txn_q.index == IDX_W'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_ready     = m_pready[k];
        sel_err       = m_pslverr[k];
        sel_rdata     = m_prdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout = (TIMEOUT_CYCLES > 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    pref_wr_d = pref_wr_q;
    unique case (state_q)
      IDLE: begin
        if (grant_wr || grant_rd) begin
          txn_d.addr         = MAX_AW'(req_addr);
          txn_d.data         = grant_wr ? MAX_DW'(s_wdata) : '0;
          txn_d.strb         = grant_wr ? MAX_SW'(s_wstrb) : '0;
          txn_d.write        = grant_wr;
          txn_d.index        = dec_idx;
          txn_d.valid_decode = dec_hit;
          pref_wr_d          = grant_rd;
          rdata_d            = '0;
          resp_d             = dec_hit ? RESP_OKAY : RESP_DECERR;
          state_d            = dec_hit ? SETUP : RESP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          resp_d  = sel_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d = txn_q.write ? '0 : sel_rdata;
          state_d = RESP;
        end else if (timeout) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (txn_q.write ? s_bready : s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      txn_q     <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      cnt_q     <= '0;
      pref_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      txn_q     <= txn_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      pref_wr_q <= pref_wr_d;
    end
  end

  assign s_awready = grant_wr;
  assign s_wready  = grant_wr;
  assign s_arready = grant_rd;
  assign s_bvalid  = (state_q == RESP) && txn_q.write;
  assign s_rvalid  = (state_q == RESP) && !txn_q.write;
  assign s_bresp   = resp_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;

  assign m_psel    = ((state_q == SETUP || state_q == ACCESS) && txn_q.valid_decode) ? sel_onehot : '0;
  assign m_penable = (state_q == ACCESS);
  assign m_paddr   = txn_q.addr[ADDR_WIDTH-1:0] & OFF_MASK;
  assign m_pwdata  = txn_q.data[DATA_WIDTH-1:0];
  assign m_pstrb   = txn_q.write ? txn_q.strb[SW-1:0] : '0;
  assign m_pwrite  = txn_q.write;
  assign m_pprot   = 3'b000;

  assign unused_txn = ^txn_q;

endmodule
